// File: rtl/fetch.sv
// fetch: LEGv8 instruction fetch stage with PC, single-outstanding imem read, IF/ID register and redirect flush
module fetch #(
  parameter int          N        = 64,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  output logic         imem_req_valid,
  input  logic         imem_req_ready,
  output logic [N-1:0] imem_addr,
  input  logic         imem_rsp_valid,
  input  logic [31:0]  imem_rsp_data,
  input  logic         redirect,
  input  logic [N-1:0] redirect_pc,
  input  logic         id_ready,
  output logic         id_valid,
  output logic [31:0]  id_instr,
  output logic [N-1:0] id_pc,
  output logic [10:0]  id_op
);
  localparam logic [1:0] REQ  = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]   state;
  logic [N-1:0] pc;
  logic [N-1:0] req_pc;
  logic         drop;
  logic         hold_valid;
  logic [31:0]  hold_instr;
  logic [N-1:0] hold_pc;
  logic         slot_free;
  logic         rsp_in_wait;

  assign imem_req_valid = reset && state == REQ && !redirect;
  assign imem_addr      = pc;
  assign id_op          = id_instr[31:21];
  assign slot_free      = !id_valid || id_ready;
  assign rsp_in_wait    = state == WAIT && imem_rsp_valid;

  // FSM, PC, IF/ID and hold buffer; redirect overrides every normal transition
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= REQ;
      pc         <= RESET_PC;
      req_pc     <= '0;
      drop       <= 1'b0;
      id_valid   <= 1'b0;
      id_instr   <= '0;
      id_pc      <= '0;
      hold_valid <= 1'b0;
      hold_instr <= '0;
      hold_pc    <= '0;
    end else if (redirect) begin
      pc         <= redirect_pc & ~N'(3);
      id_valid   <= 1'b0;
      hold_valid <= 1'b0;
      drop       <= state == WAIT && !imem_rsp_valid;
      state      <= (state == WAIT && !imem_rsp_valid) ? WAIT : REQ;
    end else begin
      if (id_valid && id_ready) id_valid <= 1'b0;
      case (state)
        REQ: if (imem_req_valid && imem_req_ready) begin
          req_pc <= pc;
          pc     <= pc + N'(4);
          state  <= WAIT;
        end
        WAIT: if (rsp_in_wait) begin
          if (drop) begin
            drop  <= 1'b0;
            state <= REQ;
          end else if (slot_free) begin
            id_instr <= imem_rsp_data;
            id_pc    <= req_pc;
            id_valid <= 1'b1;
            state    <= REQ;
          end else begin
            hold_instr <= imem_rsp_data;
            hold_pc    <= req_pc;
            hold_valid <= 1'b1;
            state      <= HOLD;
          end
        end
        HOLD: if (id_ready && hold_valid) begin
          id_instr   <= hold_instr;
          id_pc      <= hold_pc;
          id_valid   <= 1'b1;
          hold_valid <= 1'b0;
          state      <= REQ;
        end
        default: state <= REQ;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: directed self-checking bench for the fetch stage
module tb_fetch;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [63:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        id_ready = 1'b1;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [63:0] id_pc;
  logic [10:0] id_op;
  logic        auto_mem = 1'b1;
  int          vecs = 0;
  int          errs = 0;

  fetch #(.N(64), .RESET_PC(64'h40)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .id_ready(id_ready), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_op(id_op)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [63:0] a);
    return a == 64'h0 ? 32'hF840_0000 : a == 64'h4 ? 32'h8B02_0020 : {16'hD000, a[15:0]};
  endfunction

  task automatic step;
    logic        acc;
    logic [63:0] a;
    acc = imem_req_valid && imem_req_ready;
    a = imem_addr;
    @(posedge clk);
    #1;
    if (auto_mem && acc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data = memf(a);
    end else imem_rsp_valid = 1'b0;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      step();
      vecs++; if (id_valid !== 1'b0) begin errs++; $display("FAIL rst_id_valid got %b exp 0", id_valid); end
      vecs++; if (imem_req_valid !== 1'b0) begin errs++; $display("FAIL rst_req_valid got %b exp 0", imem_req_valid); end
    end
    vecs++; if (id_pc !== 64'h0 || id_instr !== 32'h0) begin errs++; $display("FAIL rst_id_regs got %h/%h exp 0/0", id_pc, id_instr); end
    reset = 1'b1;
    #1;
    vecs++; if (imem_req_valid !== 1'b1 || imem_addr !== 64'h40) begin errs++; $display("FAIL rst_first_req got %b/%h exp 1/40", imem_req_valid, imem_addr); end
    step();
    step();
    vecs++; if (imem_req_valid !== 1'b1 || imem_addr !== 64'h44) begin errs++; $display("FAIL rst_second_req got %b/%h exp 1/44", imem_req_valid, imem_addr); end
  endtask

  task automatic test_streaming;
    redirect = 1'b1;
    redirect_pc = 64'h0;
    #1;
    vecs++; if (imem_req_valid !== 1'b0) begin errs++; $display("FAIL req_redirect_gate got %b exp 0", imem_req_valid); end
    step();
    redirect = 1'b0;
    #1;
    vecs++; if (imem_req_valid !== 1'b1 || imem_addr !== 64'h0) begin errs++; $display("FAIL req_redirect_target got %b/%h exp 1/0", imem_req_valid, imem_addr); end
    step();
    step();
    vecs++; if (id_valid !== 1'b1 || id_pc !== 64'h0 || id_op !== 11'h7C2) begin errs++; $display("FAIL stream0 got %b/%h/%h exp 1/0/7c2", id_valid, id_pc, id_op); end
    step();
    vecs++; if (id_valid !== 1'b0) begin errs++; $display("FAIL stream_gap got %b exp 0", id_valid); end
    step();
    vecs++; if (id_valid !== 1'b1 || id_pc !== 64'h4 || id_op !== 11'h458) begin errs++; $display("FAIL stream1 got %b/%h/%h exp 1/4/458", id_valid, id_pc, id_op); end
  endtask

  task automatic test_stall;
    id_ready = 1'b0;
    step();
    step();
    vecs++; if (imem_req_valid !== 1'b0 || id_pc !== 64'h4 || id_valid !== 1'b1) begin errs++; $display("FAIL stall_hold got %b/%h/%b exp 0/4/1", imem_req_valid, id_pc, id_valid); end
    step();
    step();
    vecs++; if (imem_req_valid !== 1'b0 || id_pc !== 64'h4) begin errs++; $display("FAIL stall_keep got %b/%h exp 0/4", imem_req_valid, id_pc); end
    id_ready = 1'b1;
    step();
    vecs++; if (id_valid !== 1'b1 || id_pc !== 64'h8 || id_instr !== memf(64'h8)) begin errs++; $display("FAIL stall_release got %b/%h/%h exp 1/8/%h", id_valid, id_pc, id_instr, memf(64'h8)); end
    vecs++; if (imem_req_valid !== 1'b1 || imem_addr !== 64'hC) begin errs++; $display("FAIL stall_next_req got %b/%h exp 1/c", imem_req_valid, imem_addr); end
  endtask

  task automatic test_redirect_wait;
    redirect = 1'b1;
    redirect_pc = 64'h8;
    step();
    redirect = 1'b0;
    auto_mem = 1'b0;
    step();
    step();
    redirect = 1'b1;
    redirect_pc = 64'h103;
    step();
    redirect = 1'b0;
    #1;
    vecs++; if (id_valid !== 1'b0 || imem_req_valid !== 1'b0) begin errs++; $display("FAIL rdw_flush got %b/%b exp 0/0", id_valid, imem_req_valid); end
    imem_rsp_valid = 1'b1;
    imem_rsp_data = memf(64'h8);
    step();
    vecs++; if (id_valid !== 1'b0) begin errs++; $display("FAIL rdw_drop got %b exp 0", id_valid); end
    vecs++; if (imem_req_valid !== 1'b1 || imem_addr !== 64'h100) begin errs++; $display("FAIL rdw_next_req got %b/%h exp 1/100", imem_req_valid, imem_addr); end
  endtask

  task automatic test_collision;
    step();
    imem_rsp_valid = 1'b1;
    imem_rsp_data = memf(64'h100);
    redirect = 1'b1;
    redirect_pc = 64'h200;
    step();
    redirect = 1'b0;
    #1;
    vecs++; if (id_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 64'h200) begin errs++; $display("FAIL col_target got %b/%b/%h exp 0/1/200", id_valid, imem_req_valid, imem_addr); end
    step();
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'h1234_5678;
    step();
    vecs++; if (id_valid !== 1'b1 || id_pc !== 64'h200 || id_instr !== 32'h1234_5678) begin errs++; $display("FAIL col_no_drop got %b/%h/%h exp 1/200/12345678", id_valid, id_pc, id_instr); end
  endtask

  task automatic test_wrap_async;
    redirect = 1'b1;
    redirect_pc = '1;
    step();
    redirect = 1'b0;
    #1;
    vecs++; if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin errs++; $display("FAIL wrap_align got %h exp fffffffffffffffc", imem_addr); end
    auto_mem = 1'b1;
    step();
    step();
    vecs++; if (id_valid !== 1'b1 || id_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin errs++; $display("FAIL wrap_id_pc got %b/%h exp 1/fffffffffffffffc", id_valid, id_pc); end
    vecs++; if (imem_req_valid !== 1'b1 || imem_addr !== 64'h0) begin errs++; $display("FAIL wrap_zero got %b/%h exp 1/0", imem_req_valid, imem_addr); end
    auto_mem = 1'b0;
    id_ready = 1'b0;
    step();
    vecs++; if (id_valid !== 1'b1 || imem_req_valid !== 1'b0) begin errs++; $display("FAIL async_pre got %b/%b exp 1/0", id_valid, imem_req_valid); end
    #3;
    reset = 1'b0;
    #1;
    vecs++; if (id_valid !== 1'b0 || imem_addr !== 64'h40 || imem_req_valid !== 1'b0) begin errs++; $display("FAIL async_reset got %b/%h/%b exp 0/40/0", id_valid, imem_addr, imem_req_valid); end
    #2;
    reset = 1'b1;
    id_ready = 1'b1;
    #1;
    vecs++; if (imem_req_valid !== 1'b1 || imem_addr !== 64'h40) begin errs++; $display("FAIL async_release got %b/%h exp 1/40", imem_req_valid, imem_addr); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall();
    test_redirect_wait();
    test_collision();
    test_wrap_async();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
